// File: rtl/hasti_sram.sv
// Zero-wait-state HASTI slave over a single-port synchronous SRAM, with byte/halfword/word lanes.
// Latency: write data is committed in its data phase; read data returns one cycle after the address phase.
// Backpressure: one wait state when a read address phase meets a write data phase; illegal transfers get a two-cycle ERROR.
module hasti_sram #(
  parameter int SIZE_BYTES = 65536
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [3:0]  hprot,
  input  logic [1:0]  htrans,
  input  logic        hmastlock,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic        hresp
);

  localparam int AW = $clog2(SIZE_BYTES) - 2;

  typedef enum logic [2:0] {
    DP_IDLE,
    DP_READ,
    DP_WRITE,
    DP_WSTALL,
    DP_ERR1,
    DP_ERR2
  } dp_state_t;

  dp_state_t       state;
  dp_state_t       acc_next;

  logic [31:0]     mem [0:(1<<AW)-1];
  logic [31:0]     rd_q;

  logic [AW-1:0]   dp_idx;
  logic [3:0]      dp_mask;
  logic            dp_write;

  logic            acc;
  logic            illegal;
  logic [3:0]      ap_mask;
  logic            conflict;
  logic            rd_en;
  logic            wr_en;
  logic [AW-1:0]   ap_idx;

  // Burst, protection and lock attributes carry no meaning for a flat SRAM.
  logic            unused_bits;
  assign unused_bits = ^{hburst, hprot, hmastlock, htrans[0], haddr[31:AW+2]};

  assign acc      = hsel & hready & htrans[1];
  assign ap_idx   = haddr[AW+1:2];
  assign illegal  = (hsize > 3'd2)
                  | ((hsize == 3'd1) & haddr[0])
                  | ((hsize == 3'd2) & (haddr[1:0] != 2'b00));
  // A read address phase colliding with our write data phase must wait one cycle for the port.
  assign conflict = hsel & htrans[1] & ~hwrite;
  assign rd_en    = acc & ~hwrite & ~illegal;
  assign wr_en    = hresetn & (state == DP_WRITE) & dp_write;

  // Little-endian lane enables for the transfer in its address phase.
  always_comb begin
    ap_mask = 4'b1111;
    case (hsize)
      3'd0:    ap_mask = 4'b0001 << haddr[1:0];
      3'd1:    ap_mask = haddr[1] ? 4'b1100 : 4'b0011;
      default: ap_mask = 4'b1111;
    endcase
  end

  // Data-phase state that a newly accepted transfer would enter.
  always_comb begin
    acc_next = DP_IDLE;
    if (acc) begin
      if (illegal)     acc_next = DP_ERR1;
      else if (hwrite) acc_next = DP_WRITE;
      else             acc_next = DP_READ;
    end
  end

  // Data-phase FSM; a stall or first error cycle always completes before new work is taken.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state <= DP_IDLE;
    end else begin
      case (state)
        DP_WRITE: state <= conflict ? DP_WSTALL : acc_next;
        DP_ERR1:  state <= DP_ERR2;
        default:  state <= acc_next;
      endcase
    end
  end

  // Capture address-phase control only for transfers actually accepted.
  always_ff @(posedge hclk) begin
    if (acc) begin
      dp_idx   <= ap_idx;
      dp_mask  <= ap_mask;
      dp_write <= hwrite;
    end
  end

  // Single array port: writes land in the data phase, reads launch in the accept cycle.
  always_ff @(posedge hclk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (dp_mask[i]) mem[dp_idx][8*i +: 8] <= hwdata[8*i +: 8];
      end
    end
    if (rd_en) rd_q <= mem[ap_idx];
  end

  // Bus response decoded from the data-phase state.
  always_comb begin
    hreadyout = 1'b1;
    hresp     = 1'b0;
    hrdata    = 32'h0;
    case (state)
      DP_READ:  hrdata    = rd_q;
      DP_WRITE: hreadyout = ~conflict;
      DP_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
      end
      DP_ERR2:  hresp     = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hasti_sram.sv
module tb_hasti_sram;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] NONSEQ = 2'd2;
  localparam logic [31:0] B     = 32'h1000_0000;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic        hmastlock;
  logic [31:0] hwdata;
  logic        hready;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic        hresp;

  int passed = 0;
  int total  = 0;

  logic [31:0] model [int];
  logic [31:0] sb [$];
  logic        pend_wr = 1'b0;
  logic        pend_rd = 1'b0;
  int          pend_idx = 0;
  logic [3:0]  pend_mask = 4'h0;
  logic        chk_zero = 1'b0;

  always #5 hclk = ~hclk;

  // Only slave on the bus: the muxed HREADY is our own hreadyout.
  assign hready = hreadyout;

  hasti_sram #(.SIZE_BYTES(65536)) dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .hsel      (hsel),
    .haddr     (haddr),
    .hwrite    (hwrite),
    .hsize     (hsize),
    .hburst    (hburst),
    .hprot     (hprot),
    .htrans    (htrans),
    .hmastlock (hmastlock),
    .hwdata    (hwdata),
    .hready    (hready),
    .hrdata    (hrdata),
    .hreadyout (hreadyout),
    .hresp     (hresp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic is_bad(input logic [2:0] size, input logic [31:0] addr);
    if (size == 3'd0) return 1'b0;
    if (size == 3'd1) return addr[0];
    if (size == 3'd2) return addr[1:0] != 2'b00;
    return 1'b1;
  endfunction

  function automatic logic [3:0] lanes(input logic [2:0] size, input logic [31:0] addr);
    if (size == 3'd0) return 4'b0001 << addr[1:0];
    if (size == 3'd1) return addr[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  // One bus cycle: drive address phase plus write data, check the data-phase response.
  task automatic step(input logic sel, input logic [1:0] trans, input logic wr,
                      input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic exp_rdy, input logic exp_resp, input string tag);
    logic [31:0] exp;
    hsel = sel; htrans = trans; hwrite = wr; hsize = size; haddr = addr; hwdata = wdata;
    if (pend_wr) begin
      for (int i = 0; i < 4; i++)
        if (pend_mask[i]) model[pend_idx][8*i +: 8] = wdata[8*i +: 8];
    end
    @(negedge hclk);
    chk({tag, "_rdy"}, {31'h0, hreadyout}, {31'h0, exp_rdy});
    chk({tag, "_resp"}, {31'h0, hresp}, {31'h0, exp_resp});
    if (pend_rd) begin
      exp = sb.pop_front();
      chk({tag, "_rdata"}, hrdata, exp);
    end
    if (chk_zero) chk({tag, "_rdata0"}, hrdata, 32'h0);
    pend_wr = 1'b0;
    pend_rd = 1'b0;
    if (sel && trans[1] && exp_rdy && !is_bad(size, addr)) begin
      pend_idx = int'(addr[15:2]);
      if (wr) begin
        pend_wr   = 1'b1;
        pend_mask = lanes(size, addr);
      end else begin
        sb.push_back(model[pend_idx]);
        pend_rd = 1'b1;
      end
    end
    @(posedge hclk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    hresetn = 1'b0; hsel = 1'b0; haddr = 32'h0; hwrite = 1'b0; hsize = 3'd2;
    hburst = 3'd0; hprot = 4'h3; htrans = IDLE; hmastlock = 1'b0; hwdata = 32'h0;
    @(posedge hclk);
    #1;

    // Reset state
    chk_zero = 1'b1;
    step(0, IDLE, 0, 2, 0, 0, 1, 0, "rst");
    hresetn = 1'b1;
    step(0, IDLE, 0, 2, 0, 0, 1, 0, "rst_rel");
    chk_zero = 1'b0;

    // Word write then read
    step(1, NONSEQ, 1, 2, B + 32'h10, 0,            1, 0, "w1_ap");
    step(1, IDLE,   0, 2, 0,          32'hDEADBEEF, 1, 0, "w1_dp");
    step(1, NONSEQ, 0, 2, B + 32'h10, 0,            1, 0, "r1_ap");
    step(0, IDLE,   0, 2, 0,          0,            1, 0, "r1_dp");

    // Byte and halfword lanes over a preloaded word
    step(1, NONSEQ, 1, 2, B + 32'h30, 0,            1, 0, "ln_w");
    step(1, NONSEQ, 1, 0, B + 32'h31, 32'h11223344, 1, 0, "ln_b");
    step(1, NONSEQ, 1, 1, B + 32'h32, 32'hAAAAAAAA, 1, 0, "ln_h");
    step(1, IDLE,   0, 2, 0,          32'hBBCCBBCC, 1, 0, "ln_hdp");
    step(1, NONSEQ, 0, 2, B + 32'h30, 0,            1, 0, "ln_r");
    step(0, IDLE,   0, 2, 0,          0,            1, 0, "ln_rdp");
    chk("ln_value", model[int'(B[15:2]) + 12], 32'hBBCCAA44);

    // Write immediately followed by read of the same word
    step(1, NONSEQ, 1, 2, B + 32'h20, 0,            1, 0, "cf_w");
    step(1, NONSEQ, 0, 2, B + 32'h20, 32'h12345678, 0, 0, "cf_stall");
    step(1, NONSEQ, 0, 2, B + 32'h20, 0,            1, 0, "cf_r");
    step(0, IDLE,   0, 2, 0,          0,            1, 0, "cf_rdp");

    // Illegal transfers: misaligned word write, then oversize read
    step(1, NONSEQ, 1, 2, B + 32'h32, 0,            1, 0, "il1_ap");
    step(1, IDLE,   0, 2, 0,          32'hFFFFFFFF, 0, 1, "il1_e1");
    step(1, IDLE,   0, 2, 0,          0,            1, 1, "il1_e2");
    step(1, NONSEQ, 0, 3, B + 32'h30, 0,            1, 0, "il2_ap");
    step(1, IDLE,   0, 2, 0,          0,            0, 1, "il2_e1");
    step(1, IDLE,   0, 2, 0,          0,            1, 1, "il2_e2");
    step(1, NONSEQ, 0, 2, B + 32'h30, 0,            1, 0, "il_rb");
    step(0, IDLE,   0, 2, 0,          0,            1, 0, "il_rbdp");

    // Back-to-back writes and reads with BUSY/IDLE interleaved
    step(1, NONSEQ, 1, 2, B + 32'h40, 0,            1, 0, "bb_w40");
    step(1, BUSY,   0, 2, B + 32'h44, 32'h01010101, 1, 0, "bb_busy");
    step(1, NONSEQ, 1, 2, B + 32'h44, 0,            1, 0, "bb_w44");
    step(1, NONSEQ, 0, 2, B + 32'h40, 32'h02020202, 0, 0, "bb_stall");
    step(1, NONSEQ, 0, 2, B + 32'h40, 0,            1, 0, "bb_r40");
    step(1, NONSEQ, 0, 2, B + 32'h44, 0,            1, 0, "bb_r44");
    step(1, IDLE,   0, 2, 0,          0,            1, 0, "bb_idle");
    step(0, IDLE,   0, 2, 0,          0,            1, 0, "bb_end");

    // Reset asserted during the write stall cycle
    step(1, NONSEQ, 1, 2, B + 32'h50, 0,            1, 0, "rs_w");
    step(1, NONSEQ, 0, 2, B + 32'h50, 32'hCAFEF00D, 0, 0, "rs_stall");
    hresetn = 1'b0;
    step(1, NONSEQ, 0, 2, B + 32'h50, 0,            1, 0, "rs_wstall");
    hresetn = 1'b1;
    pend_rd = 1'b0;
    pend_wr = 1'b0;
    sb.delete();
    chk_zero = 1'b1;
    step(1, IDLE,   0, 2, 0,          0,            1, 0, "rs_after");
    chk_zero = 1'b0;
    step(1, NONSEQ, 0, 2, B + 32'h50, 0,            1, 0, "rs_r");
    step(0, IDLE,   0, 2, 0,          0,            1, 0, "rs_rdp");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
